// File: rtl/noc_class_router.sv
`default_nettype none
//------------------------------------------------------------------------------
// noc_class_router : sorts packets into four per-class FIFOs and re-serialises
// them onto one registered port. Macro NOC_STRICT_PRIO_EN selects strict priority.
// Rev 1.0
//------------------------------------------------------------------------------
module noc_class_router #(
    parameter int  PW    = 8,
    parameter int  AW    = 2,
    parameter int  DEPTH = 4,
    localparam int W     = PW + AW + 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      in_packet,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      out_packet,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*CW-1:0]   class_count,
    output logic [3:0]        class_full,
    output logic [7:0]        drop_count
);
    localparam int            C_PTRW  = $clog2(DEPTH);
    localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);

    logic          w_marker;
    logic [1:0]    w_type;
    logic          w_accept;
    logic          w_load;
    logic          w_any;
    logic [1:0]    w_grant;
    logic [3:0]    w_nonempty;
    logic [3:0]    w_full;
    logic [W-1:0]  w_head [4];

    logic [W-1:0]  r_out_packet;
    logic          r_out_valid;
    logic [7:0]    r_drop;

    assign w_marker = in_packet[W-1];
    assign w_type   = in_packet[AW+1:AW];
    // Ready is driven from the registered full flag, so a same-cycle pop never frees a slot early.
    assign in_ready = reset && (!w_marker || !w_full[w_type]);
    assign w_accept = in_valid && in_ready;
    assign w_load   = !r_out_valid || out_ready;
    assign w_any    = |w_nonempty;

    generate
        for (genvar c = 0; c < 4; c++) begin : g_class
            logic [C_PTRW-1:0] r_wptr;
            logic [C_PTRW-1:0] r_rptr;
            logic [CW-1:0]     r_count;
            logic              r_full;
            logic [W-1:0]      r_mem [DEPTH];
            logic              w_push;
            logic              w_pop;
            logic [CW-1:0]     w_count_nxt;

            assign w_push      = w_accept && w_marker && (w_type == 2'(c));
            assign w_pop       = w_load && w_any && (w_grant == 2'(c));
            assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_full  <= 1'b0;
                end else begin
                    if (w_push) r_wptr <= r_wptr + C_PTRW'(1);
                    if (w_pop)  r_rptr <= r_rptr + C_PTRW'(1);
                    r_count <= w_count_nxt;
                    r_full  <= (w_count_nxt == C_FULL);
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) r_mem[r_wptr] <= in_packet;
            end

            assign w_head[c]                = r_mem[r_rptr];
            assign w_nonempty[c]            = (r_count != '0);
            assign w_full[c]                = r_full;
            assign class_count[c*CW +: CW]  = r_count;
        end
    endgenerate

`ifdef NOC_STRICT_PRIO_EN
    always_comb begin
        w_grant = 2'd0;
        if (w_nonempty[1])      w_grant = 2'd1;
        else if (w_nonempty[2]) w_grant = 2'd2;
        else if (w_nonempty[0]) w_grant = 2'd0;
        else if (w_nonempty[3]) w_grant = 2'd3;
    end
`else
    logic [1:0] r_last_grant;
    logic [1:0] w_cand;

    // Scan from farthest to nearest so the class closest after last_grant wins.
    always_comb begin
        w_grant = r_last_grant;
        w_cand  = r_last_grant;
        for (int i = 4; i >= 1; i--) begin
            w_cand = r_last_grant + 2'(i);
            if (w_nonempty[w_cand]) w_grant = w_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)               r_last_grant <= 2'd3;
        else if (w_load && w_any) r_last_grant <= w_grant;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) r_out_packet <= w_head[w_grant];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)                                         r_drop <= 8'd0;
        else if (w_accept && !w_marker && r_drop != 8'hFF)  r_drop <= r_drop + 8'd1;
    end

    assign out_packet = r_out_packet;
    assign out_valid  = r_out_valid;
    assign class_full = w_full;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_noc_class_router.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_noc_class_router : randomized self-checking bench with a queue-based model.
// Rev 1.0
//------------------------------------------------------------------------------
module tb_noc_class_router;
    localparam int PW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int W     = PW + AW + 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            reset;
    logic [W-1:0]    in_packet;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_packet;
    logic            out_valid;
    logic            out_ready;
    logic [4*CW-1:0] class_count;
    logic [3:0]      class_full;
    logic [7:0]      drop_count;

    noc_class_router #(.PW(PW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_packet   (in_packet),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_packet  (out_packet),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_count (class_count),
        .class_full  (class_full),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one queue per class, an output slot and a drop tally.
    logic [W-1:0] mq [4][$];
    logic         m_ov;
    logic [W-1:0] m_out;
    int           m_last;
    int           m_drop;
    logic         e_ready;
    logic         o_ready;

    function automatic int pick();
        int order [4];
`ifdef NOC_STRICT_PRIO_EN
        order = '{1, 2, 0, 3};
`else
        for (int k = 0; k < 4; k++) order[k] = (m_last + 1 + k) % 4;
`endif
        for (int k = 0; k < 4; k++)
            if (mq[order[k]].size() > 0) return order[k];
        return -1;
    endfunction

    function automatic logic [4*CW-1:0] exp_count();
        logic [4*CW-1:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*CW +: CW] = CW'(mq[c].size());
        return v;
    endfunction

    function automatic logic [3:0] exp_full();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = (mq[c].size() == DEPTH);
        return v;
    endfunction

    function automatic logic [W-1:0] mkpkt(input logic mk, input logic [1:0] ty);
        logic [PW-1:0] pl;
        logic [AW-1:0] ad;
        pl = PW'($urandom);
        ad = AW'($urandom);
        return {mk, pl, ty, ad};
    endfunction

    // Drive one cycle, capture in_ready against the model, advance model past the edge.
    task automatic tick(input logic rst_n, input logic v, input logic [W-1:0] pkt, input logic ordy);
        int g;
        reset     = rst_n;
        in_valid  = v;
        in_packet = pkt;
        out_ready = ordy;
        #1;
        e_ready = rst_n && (!pkt[W-1] || mq[pkt[AW+1:AW]].size() < DEPTH);
        o_ready = in_ready;
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            m_ov = 1'b0; m_out = '0; m_last = 3; m_drop = 0;
        end else begin
            if (!m_ov || ordy) begin
                g = pick();
                if (g >= 0) begin
                    m_out = mq[g].pop_front(); m_ov = 1'b1; m_last = g;
                end else m_ov = 1'b0;
            end
            if (v && e_ready) begin
                if (pkt[W-1]) mq[pkt[AW+1:AW]].push_back(pkt);
                else if (m_drop < 255) m_drop++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, mkpkt(1'b1, 2'(i)), 1'b1);
            checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", o_ready); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_packet !== '0) begin errors++; $display("FAIL reset_out_packet got %h want 0", out_packet); end
        checks++; if (class_count !== '0) begin errors++; $display("FAIL reset_count got %h want 0", class_count); end
        checks++; if (class_full !== 4'b0) begin errors++; $display("FAIL reset_full got %b want 0", class_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    endtask

    task automatic test_single();
        logic [W-1:0] p;
        p = {1'b1, 8'hA5, 2'b01, 2'b10};
        tick(1'b1, 1'b1, p, 1'b1);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", o_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", out_valid); end
        checks++; if (class_count !== 12'h008) begin errors++; $display("FAIL single_count1 got %h want 008", class_count); end
        tick(1'b1, 1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_packet !== 13'h1A56) begin errors++; $display("FAIL single_packet got %h want 1a56", out_packet); end
        checks++; if (class_count !== 12'h000) begin errors++; $display("FAIL single_count0 got %h want 000", class_count); end
        tick(1'b1, 1'b0, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_clear got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        tick(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, mkpkt(1'b1, 2'b00), 1'b0);
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b want 1", i, o_ready); end
        end
        checks++; if (class_full !== 4'b0001) begin errors++; $display("FAIL bp_full got %b want 0001", class_full); end
        checks++; if (class_count !== exp_count()) begin errors++; $display("FAIL bp_count got %h want %h", class_count, exp_count()); end
        tick(1'b1, 1'b1, mkpkt(1'b1, 2'b00), 1'b0);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_sixth got %b want 0", o_ready); end
        tick(1'b1, 1'b1, mkpkt(1'b1, 2'b01), 1'b0);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_other_class got %b want 1", o_ready); end
        checks++; if (class_count[CW +: CW] !== CW'(1)) begin errors++; $display("FAIL bp_ctrl_count got %0d want 1", class_count[CW +: CW]); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== m_ov || (m_ov && out_packet !== m_out)) begin
                errors++; $display("FAIL bp_drain%0d got %b/%h want %b/%h", i, out_valid, out_packet, m_ov, m_out); end
            tick(1'b1, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_arbiter();
        int pre [8];
        int want [8];
`ifdef NOC_STRICT_PRIO_EN
        pre  = '{1, 0, 2, 3, 1, 0, 2, 3};
        want = '{1, 1, 2, 2, 0, 0, 3, 3};
`else
        pre  = '{0, 1, 2, 3, 0, 1, 2, 3};
        want = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        tick(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, mkpkt(1'b1, 2'(pre[i])), 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_packet[AW+1:AW] !== 2'(want[i])) begin
                errors++; $display("FAIL arb_order%0d got %b/%0d want 1/%0d", i, out_valid, out_packet[AW+1:AW], want[i]); end
            checks++; if (out_packet !== m_out) begin errors++; $display("FAIL arb_pkt%0d got %h want %h", i, out_packet, m_out); end
            tick(1'b1, 1'b0, '0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arb_empty got %b want 0", out_valid); end
    endtask

    task automatic test_drops();
        int seen_valid;
        int not_ready;
        seen_valid = 0; not_ready = 0;
        tick(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1, mkpkt(1'b0, 2'($urandom)), 1'($urandom));
            if (o_ready !== 1'b1) not_ready++;
            if (out_valid !== 1'b0) seen_valid++;
        end
        checks++; if (not_ready != 0) begin errors++; $display("FAIL drop_ready got %0d stalls want 0", not_ready); end
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL drop_out_valid got %0d cycles want 0", seen_valid); end
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_count); end
        checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL drop_model got %0d want %0d", drop_count, m_drop); end
        checks++; if (class_count !== '0) begin errors++; $display("FAIL drop_count0 got %h want 0", class_count); end
    endtask

    task automatic test_random();
        logic rst_n;
        tick(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            tick(rst_n, ($urandom_range(0, 9) < 7), mkpkt(($urandom_range(0, 9) != 0), 2'($urandom)),
                 ($urandom_range(0, 9) < 6));
            checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_in_ready@%0d got %b want %b", i, o_ready, e_ready); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid@%0d got %b want %b", i, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_packet !== m_out) begin errors++; $display("FAIL rnd_packet@%0d got %h want %h", i, out_packet, m_out); end
            end
            checks++; if (class_count !== exp_count()) begin errors++; $display("FAIL rnd_count@%0d got %h want %h", i, class_count, exp_count()); end
            checks++; if (class_full !== exp_full()) begin errors++; $display("FAIL rnd_full@%0d got %b want %b", i, class_full, exp_full()); end
            checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop@%0d got %0d want %0d", i, drop_count, m_drop); end
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_packet = '0; out_ready = 1'b0;
        m_ov = 1'b0; m_out = '0; m_last = 3; m_drop = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_arbiter();
        test_drops();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
